vid_sequencer: RTL and testbench
================================

Name: vid_sequencer

Overview:
- Parametrised character-period sequencer for the MDA/HGC-class display path.
- Divides `clk` into a per-mode character period and decodes VRAM fetch, char-ROM, display-pipeline and CRTC clock strobes from the count.
- Arbitrates ISA access windows with an explicit request/grant handshake that guarantees a gap before the next VRAM fetch.
- Adds two things over the fixed-timing sequencer: mode changes that apply only at period boundaries, and multiple graphics fetch slots per period.

Parameters:
- CNT_W, 5: width of clk_seq; must hold max(TEXT_PERIOD, GRPH_PERIOD)-1.
- TEXT_PERIOD, 18: clocks per character period in text mode.
- GRPH_PERIOD, 32: clocks per period in graphics mode; must be even.
- GRPH_SLOTS, 2: graphics fetch slots per period. Legal values are 1 or 2. Slot k has base b = k*GRPH_PERIOD/2.
- ISA_WIN_START, 6: earliest grant offset after each slot base (after 0 in text mode).
- ISA_OP_LEN, 3: clocks an ISA operation occupies VRAM.
- ISA_GAP, 2: idle clocks required between the end of an ISA operation and the next vram_read.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- grph_mode  in  1  requested mode (1 = graphics)
- mode_active  out  1  mode currently applied to decoding
- clk_seq  out  CNT_W  current period counter
- crtc_clk  out  1  one-clock pulse per period
- vram_read  out  1  VRAM fetch in progress
- vram_read_a0  out  1  address-bit-0 / char fetch phase
- vram_read_char  out  1  character byte latch strobe
- vram_read_att  out  1  attribute byte latch strobe
- charrom_read  out  1  char ROM read strobe (text only)
- disp_pipeline  out  1  display pipeline advance (text only)
- isa_req  in  1  ISA access request; held high until granted
- isa_grant  out  1  one-clock grant pulse
- isa_busy  out  1  ISA operation owns VRAM

Behaviour:
- Reset:
  - clk_seq = 0, crtc_clk = 0, isa_grant = 0, isa_busy = 0.
  - mode_active loads grph_mode.
  - All decoded strobes are forced 0 while reset is high.
- Period P = TEXT_PERIOD if mode_active = 0, else GRPH_PERIOD. Counter increments each clock and wraps from P-1 to 0.
- Mode switching:
  - mode_active re-samples grph_mode only on the wrap clock (clk_seq = P-1).
  - A mid-period change of grph_mode has no effect until the following period starts at 0.
  - A toggle back before the wrap is never seen.
- crtc_clk is registered and high exactly in cycles where clk_seq = 0, except the first period after reset.
- Text strobes (combinational from clk_seq, mode_active):
  - vram_read at 1..4.
  - vram_read_a0 and vram_read_char at 3.
  - vram_read_att at 4.
  - charrom_read at 1.
  - disp_pipeline at 4.
- Graphics strobes, for each slot base b:
  - vram_read at b+1..b+3.
  - vram_read_a0 and vram_read_char at b+2.
  - vram_read_att at b+3.
  - charrom_read = disp_pipeline = 0.
- ISA next-read distance R(g) = offset of the next vram_read start after count g. A read at the next period's count 1 counts as P+1. The distance uses the current mode_active.
- Grant rule:
  - isa_grant is registered. It is high in a cycle whose clk_seq = g only if all of the following hold:
    - isa_req was high in the preceding cycle;
    - isa_busy is 0 and isa_grant is not already high;
    - g >= b+ISA_WIN_START for the most recent slot base b (0 in text);
    - g + ISA_OP_LEN + ISA_GAP <= R(g);
    - g is not a vram_read cycle.
- Busy: isa_busy is high for ISA_OP_LEN clocks starting with the grant cycle. No further grant is issued while it is high.
- Default eligible grant windows:
  - text: g in 6..14 (R = 19);
  - graphics, 2 slots: 6..12 and 22..28;
  - graphics, 1 slot: 6..28.
- Requests not eligible are held off; the grant occurs at the first eligible cycle, possibly in a later period.
- Mode switch at wrap is safe because eligibility always leaves ISA_GAP before period count 1.
- Reset mid-operation clears isa_busy and isa_grant immediately. The requester must re-request.

Test Plan:
- Reset with grph_mode = 0, release → mode_active = 0; clk_seq runs 0..17 and wraps; crtc_clk first high at the second clk_seq = 0; vram_read at 1–4, char at 3, att at 4, charrom_read at 1.
- grph_mode = 1 from reset → period 32; vram_read at 1–3 and 17–19; char at 2 and 18; att at 3 and 19; charrom_read and disp_pipeline never high.
- In text mode, raise grph_mode at clk_seq = 7 → mode_active stays 0 until clk_seq wraps at 17, then period becomes 32; a pulse of grph_mode from count 8 to 12 has no effect.
- Text mode, isa_req high from clk_seq = 2 → isa_grant at clk_seq = 6 only; isa_busy at 6–8; drop req at 6 → no second grant.
- Graphics 2-slot, isa_req raised at clk_seq = 13 → no grant until clk_seq = 22; isa_busy at 22–24; vram_read never overlaps isa_busy.
- Assert reset at the cycle after the grant (busy high) → next cycle isa_busy = 0, clk_seq = 0, all strobes 0 while reset is held.

Source files
------------

// File: rtl/vid_sequencer.sv
// Character-period sequencer: divides clk into a per-mode period, decodes VRAM/char-ROM/CRTC strobes
// and grants ISA VRAM windows that always leave a gap before the next fetch.
module vid_sequencer #(
    parameter int CNT_W         = 5,
    parameter int TEXT_PERIOD   = 18,
    parameter int GRPH_PERIOD   = 32,
    parameter int GRPH_SLOTS    = 2,
    parameter int ISA_WIN_START = 6,
    parameter int ISA_OP_LEN    = 3,
    parameter int ISA_GAP       = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             grph_mode,
    output logic             mode_active,
    output logic [CNT_W-1:0] clk_seq,
    output logic             crtc_clk,
    output logic             vram_read,
    output logic             vram_read_a0,
    output logic             vram_read_char,
    output logic             vram_read_att,
    output logic             charrom_read,
    output logic             disp_pipeline,
    input  logic             isa_req,
    output logic             isa_grant,
    output logic             isa_busy
);

    localparam int HALF = GRPH_PERIOD / 2;
    localparam int BW   = $clog2(ISA_OP_LEN + 1);

    function automatic int slot_base(input int g, input logic m);
        if (m && GRPH_SLOTS == 2 && g >= HALF) return HALF;
        return 0;
    endfunction

    function automatic logic is_read(input int g, input logic m);
        int o;
        o = g - slot_base(g, m);
        if (m) return (o >= 1 && o <= 3);
        return (o >= 1 && o <= 4);
    endfunction

    // Offset of the next fetch start; a fetch in the following period counts as period+1.
    function automatic int next_read(input int g, input logic m);
        if (g < 1) return 1;
        if (m && GRPH_SLOTS == 2 && g < HALF + 1) return HALF + 1;
        return (m ? GRPH_PERIOD : TEXT_PERIOD) + 1;
    endfunction

    function automatic logic grant_ok(input int g, input logic m);
        return (g >= slot_base(g, m) + ISA_WIN_START) &&
               (g + ISA_OP_LEN + ISA_GAP <= next_read(g, m)) &&
               !is_read(g, m);
    endfunction

    logic [BW-1:0]    busy_cnt;
    logic [CNT_W-1:0] nxt_seq;
    logic             nxt_mode;
    logic             wrap;
    logic             grant_now;
    int               period;
    int               dec_off;

    // Grant eligibility is judged against the count and mode of the cycle the grant will appear in.
    always_comb begin
        period    = mode_active ? GRPH_PERIOD : TEXT_PERIOD;
        wrap      = (int'(clk_seq) == period - 1);
        nxt_seq   = wrap ? '0 : clk_seq + CNT_W'(1);
        nxt_mode  = wrap ? grph_mode : mode_active;
        grant_now = isa_req && (busy_cnt == '0) && !isa_grant &&
                    grant_ok(int'(nxt_seq), nxt_mode);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_seq     <= '0;
            crtc_clk    <= 1'b0;
            isa_grant   <= 1'b0;
            busy_cnt    <= '0;
            mode_active <= grph_mode;
        end else begin
            clk_seq     <= nxt_seq;
            crtc_clk    <= wrap;
            mode_active <= nxt_mode;
            isa_grant   <= grant_now;
            if (grant_now)
                busy_cnt <= BW'(ISA_OP_LEN);
            else if (busy_cnt != '0)
                busy_cnt <= busy_cnt - BW'(1);
        end
    end

    assign isa_busy = (busy_cnt != '0);

    always_comb begin
        vram_read      = 1'b0;
        vram_read_a0   = 1'b0;
        vram_read_char = 1'b0;
        vram_read_att  = 1'b0;
        charrom_read   = 1'b0;
        disp_pipeline  = 1'b0;
        dec_off        = int'(clk_seq) - slot_base(int'(clk_seq), mode_active);
        if (!reset) begin
            if (mode_active) begin
                vram_read      = (dec_off >= 1 && dec_off <= 3);
                vram_read_a0   = (dec_off == 2);
                vram_read_char = (dec_off == 2);
                vram_read_att  = (dec_off == 3);
            end else begin
                vram_read      = (dec_off >= 1 && dec_off <= 4);
                vram_read_a0   = (dec_off == 3);
                vram_read_char = (dec_off == 3);
                vram_read_att  = (dec_off == 4);
                charrom_read   = (dec_off == 1);
                disp_pipeline  = (dec_off == 4);
            end
        end
    end

endmodule

// File: tb/tb_vid_sequencer.sv
// Directed plus randomized bench for vid_sequencer against a table-driven reference of the timing rules.
module tb_vid_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       grph_mode = 1'b0;
    logic       isa_req = 1'b0;
    logic       mode_active;
    logic [4:0] clk_seq;
    logic       crtc_clk, vram_read, vram_read_a0, vram_read_char, vram_read_att;
    logic       charrom_read, disp_pipeline, isa_grant, isa_busy;

    vid_sequencer dut (
        .clk(clk), .reset(reset), .grph_mode(grph_mode), .mode_active(mode_active),
        .clk_seq(clk_seq), .crtc_clk(crtc_clk), .vram_read(vram_read),
        .vram_read_a0(vram_read_a0), .vram_read_char(vram_read_char),
        .vram_read_att(vram_read_att), .charrom_read(charrom_read),
        .disp_pipeline(disp_pipeline), .isa_req(isa_req), .isa_grant(isa_grant),
        .isa_busy(isa_busy)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    int m_seq  = 0;
    bit m_mode = 0;
    bit m_crtc = 0;
    bit m_grant = 0;
    int m_left = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Default grant windows: text 6..14, graphics two slots 6..12 and 22..28.
    function automatic bit in_window(input int g, input bit m);
        if (!m) return (g >= 6 && g <= 14);
        return (g >= 6 && g <= 12) || (g >= 22 && g <= 28);
    endfunction

    // {vram_read, a0, char, att, charrom, disp}
    function automatic logic [5:0] exp_strobes(input int s, input bit m, input logic r);
        if (r) return 6'b0;
        if (!m) begin
            case (s)
                1: return 6'b100010;
                2: return 6'b100000;
                3: return 6'b111000;
                4: return 6'b100101;
                default: return 6'b0;
            endcase
        end
        case (s % 16)
            1: return 6'b100000;
            2: return 6'b111000;
            3: return 6'b100100;
            default: return 6'b0;
        endcase
    endfunction

    task automatic model_update(input logic r, input logic g, input logic q);
        int period;
        bit prev_busy, prev_grant;
        if (r) begin
            m_seq = 0; m_crtc = 0; m_grant = 0; m_left = 0; m_mode = g;
        end else begin
            period     = m_mode ? 32 : 18;
            prev_busy  = (m_left > 0);
            prev_grant = m_grant;
            if (m_seq == period - 1) begin
                m_seq  = 0;
                m_mode = g;
            end else begin
                m_seq = m_seq + 1;
            end
            m_crtc  = (m_seq == 0);
            m_grant = q && !prev_busy && !prev_grant && in_window(m_seq, m_mode);
            if (m_grant) m_left = 3;
            else if (m_left > 0) m_left = m_left - 1;
        end
    endtask

    task automatic check_all();
        check("clk_seq", 32'(clk_seq), 32'(m_seq));
        check("mode_active", 32'(mode_active), 32'(m_mode));
        check("crtc_clk", 32'(crtc_clk), 32'(m_crtc));
        check("isa_grant", 32'(isa_grant), 32'(m_grant));
        check("isa_busy", 32'(isa_busy), 32'(m_left > 0));
        check("strobes", 32'({vram_read, vram_read_a0, vram_read_char, vram_read_att,
                              charrom_read, disp_pipeline}),
              32'(exp_strobes(m_seq, m_mode, reset)));
        check("read_busy_overlap", 32'(vram_read & isa_busy), 32'd0);
    endtask

    task automatic step();
        logic r, g, q;
        r = reset; g = grph_mode; q = isa_req;
        @(posedge clk);
        #1;
        model_update(r, g, q);
        check_all();
    endtask

    task automatic do_reset(input logic mode);
        reset = 1'b1; grph_mode = mode; isa_req = 1'b0;
        repeat (3) step();
        reset = 1'b0;
    endtask

    task automatic wait_seq(input int target, input int budget);
        bit found = 0;
        for (int i = 0; i < budget && !found; i++) begin
            step();
            if (int'(clk_seq) == target) found = 1;
        end
        check("wait_seq_timeout", 32'(found), 32'd1);
    endtask

    task automatic wait_grant(input int budget);
        bit found = 0;
        for (int i = 0; i < budget && !found; i++) begin
            step();
            if (isa_grant) found = 1;
        end
        check("wait_grant_timeout", 32'(found), 32'd1);
    endtask

    initial begin
        int n, grants;
        bit seen;

        // Text mode from reset; first crtc_clk at the second count 0.
        do_reset(1'b0);
        check("reset_mode_text", 32'(mode_active), 32'd0);
        n = 0; seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step(); n++;
            if (crtc_clk) seen = 1;
        end
        check("first_crtc_delay", 32'(n), 32'd18);
        repeat (20) step();

        // Graphics mode from reset.
        do_reset(1'b1);
        check("reset_mode_grph", 32'(mode_active), 32'd1);
        repeat (70) step();

        // Mid-period pulse is ignored; a raise at 7 applies after the wrap.
        do_reset(1'b0);
        wait_seq(8, 40);
        grph_mode = 1'b1;
        wait_seq(12, 40);
        grph_mode = 1'b0;
        wait_seq(17, 40);
        step();
        check("pulse_ignored", 32'(mode_active), 32'd0);
        wait_seq(7, 40);
        grph_mode = 1'b1;
        wait_seq(17, 40);
        check("mode_before_wrap", 32'(mode_active), 32'd0);
        step();
        check("mode_after_wrap", 32'(mode_active), 32'd1);
        check("seq_after_wrap", 32'(clk_seq), 32'd0);
        repeat (40) step();

        // Text-mode request from count 2: grant at 6, single grant only.
        do_reset(1'b0);
        wait_seq(2, 40);
        isa_req = 1'b1;
        wait_grant(60);
        check("text_grant_seq", 32'(clk_seq), 32'd6);
        isa_req = 1'b0;
        grants = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (isa_grant) grants++;
        end
        check("text_no_second_grant", 32'(grants), 32'd0);

        // Graphics request at 13 is held off to the second slot window.
        do_reset(1'b1);
        wait_seq(13, 40);
        isa_req = 1'b1;
        wait_grant(80);
        check("grph_grant_seq", 32'(clk_seq), 32'd22);
        isa_req = 1'b0;
        repeat (40) step();

        // Reset while busy clears the operation immediately.
        do_reset(1'b0);
        wait_seq(2, 40);
        isa_req = 1'b1;
        wait_grant(60);
        isa_req = 1'b0;
        step();
        check("busy_before_reset", 32'(isa_busy), 32'd1);
        reset = 1'b1;
        #1;
        check("strobes_gated_by_reset", 32'({vram_read, vram_read_a0, vram_read_char,
              vram_read_att, charrom_read, disp_pipeline}), 32'd0);
        step();
        check("busy_cleared", 32'(isa_busy), 32'd0);
        check("seq_cleared", 32'(clk_seq), 32'd0);
        repeat (3) step();
        reset = 1'b0;

        // Randomized traffic: mode toggles, requests, occasional resets.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 59) == 0) grph_mode = ~grph_mode;
            if (reset) reset = 1'b0;
            else if ($urandom_range(0, 299) == 0) reset = 1'b1;
            if (isa_grant || reset) isa_req = 1'b0;
            else if (!isa_req && $urandom_range(0, 7) == 0) isa_req = 1'b1;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
